// File: rtl/mac_acc_pipe_pkg.sv
// Shared types and the round/shift/saturate helper for the MAC datapath and the
// planned requantiser.
`ifndef WIDTH_DATA
`define WIDTH_DATA 8
`endif

package mac_acc_pipe_pkg;

  localparam int WIDE_W = 64;

  typedef logic signed [WIDE_W-1:0] wide_t;

  // Round half up, arithmetic shift, then range-check against a signed out_w result.
  function automatic wide_t round_shift_sat(input wide_t acc, input logic [7:0] shift,
                                            input int out_w, input logic sat,
                                            output logic ovf);
    wide_t rnd;
    wide_t r;
    wide_t hi;
    wide_t lo;
    rnd = (shift == 8'd0) ? 64'sd0 : (64'sd1 <<< (shift - 8'd1));
    r   = (acc + rnd) >>> shift;
    hi  = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 1));
    ovf = (r > hi) || (r < lo);
    if (ovf && sat) begin
      return (r > hi) ? hi : lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_acc_pipe_if.sv
// Operand/result handshake bundle between the conv1d feeder, the MAC and the
// downstream consumer.
interface mac_acc_pipe_if #(
  parameter int DATA_W = `WIDTH_DATA,
  parameter int OUT_W  = 2*DATA_W
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] weight;
  logic signed [DATA_W-1:0] feature;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_ovf;

  modport master (
    output in_valid, weight, feature, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, weight, feature, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/mac_round_sat.sv
// Combinational round/shift/saturate of an accumulator value down to OUT_W bits.
module mac_round_sat
  import mac_acc_pipe_pkg::*;
#(
  parameter int ACC_W = 36,
  parameter int OUT_W = 32
) (
  input  logic signed [ACC_W-1:0]         acc,
  input  logic        [$clog2(ACC_W)-1:0] shift,
  input  logic                            sat,
  output logic signed [OUT_W-1:0]         data,
  output logic                            ovf
);

  wide_t res;
  logic  unused_hi;

  always_comb begin
    res  = round_shift_sat(WIDE_W'(acc), 8'(shift), OUT_W, sat, ovf);
    data = res[OUT_W-1:0];
  end

  // Bits above OUT_W only matter for the range check inside the helper.
  assign unused_hi = ^res[WIDE_W-1:OUT_W];

endmodule

// File: rtl/mac_acc_pipe.sv
// Pipelined signed multiply-accumulate: S1 operand register, S2 product,
// S3 accumulator, then a rounded/saturated output register with backpressure.
module mac_acc_pipe
  import mac_acc_pipe_pkg::*;
#(
  parameter int DATA_W = `WIDTH_DATA,
  parameter int K_MAX  = 16,
  parameter int ACC_W  = 2*DATA_W + $clog2(K_MAX),
  parameter int OUT_W  = 2*DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(K_MAX+1)-1:0]   cfg_k,
  input  logic [$clog2(ACC_W)-1:0]     cfg_shift,
  input  logic                         cfg_sat,
  mac_acc_pipe_if.slave                bus
);

  localparam int KW  = $clog2(K_MAX+1);
  localparam int SHW = $clog2(ACC_W);
  localparam int PW  = 2*DATA_W;

  generate
    if (ACC_W < 2*DATA_W + $clog2(K_MAX) || ACC_W > WIDE_W - 2 || OUT_W >= WIDE_W) begin : g_width_check
      $error("mac_acc_pipe: ACC_W/OUT_W outside the supported range");
    end
  endgenerate

  logic [KW-1:0]            tap_cnt_q, tap_cnt_d;
  logic [KW-1:0]            k_q, k_d;
  logic [SHW-1:0]           shift_q, shift_d;
  logic                     sat_q, sat_d;

  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_first_q, s1_first_d;
  logic                     s1_last_q, s1_last_d;
  logic signed [DATA_W-1:0] s1_w_q, s1_w_d;
  logic signed [DATA_W-1:0] s1_f_q, s1_f_d;
  logic [SHW-1:0]           s1_shift_q, s1_shift_d;
  logic                     s1_sat_q, s1_sat_d;

  logic                     s2_valid_q, s2_valid_d;
  logic                     s2_first_q, s2_first_d;
  logic                     s2_last_q, s2_last_d;
  logic signed [PW-1:0]     s2_prod_q, s2_prod_d;
  logic [SHW-1:0]           s2_shift_q, s2_shift_d;
  logic                     s2_sat_q, s2_sat_d;

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     s3_done_q, s3_done_d;
  logic [SHW-1:0]           s3_shift_q, s3_shift_d;
  logic                     s3_sat_q, s3_sat_d;

  logic                     out_valid_q, out_valid_d;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;

  logic                     adv;
  logic                     accept;
  logic                     grp_first;
  logic                     grp_last;
  logic [KW-1:0]            k_eff;
  logic [KW-1:0]            grp_k;
  logic [SHW-1:0]           grp_shift;
  logic                     grp_sat;
  logic signed [OUT_W-1:0]  rs_data;
  logic                     rs_ovf;

  // The group's config is taken live on its first tap and from the latches afterwards.
  always_comb begin
    adv    = !out_valid_q || bus.out_ready;
    accept = bus.in_valid && adv;
    if (cfg_k == '0) begin
      k_eff = KW'(1);
    end else if (cfg_k > KW'(K_MAX)) begin
      k_eff = KW'(K_MAX);
    end else begin
      k_eff = cfg_k;
    end
    grp_first = (tap_cnt_q == '0);
    grp_k     = grp_first ? k_eff     : k_q;
    grp_shift = grp_first ? cfg_shift : shift_q;
    grp_sat   = grp_first ? cfg_sat   : sat_q;
    grp_last  = (tap_cnt_q == grp_k - KW'(1));
  end

  mac_round_sat #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W)
  ) u_round_sat (
    .acc   (acc_q),
    .shift (s3_shift_q),
    .sat   (s3_sat_q),
    .data  (rs_data),
    .ovf   (rs_ovf)
  );

  always_comb begin
    tap_cnt_d   = tap_cnt_q;
    k_d         = k_q;
    shift_d     = shift_q;
    sat_d       = sat_q;
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_w_d      = s1_w_q;
    s1_f_d      = s1_f_q;
    s1_shift_d  = s1_shift_q;
    s1_sat_d    = s1_sat_q;
    s2_valid_d  = s2_valid_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_prod_d   = s2_prod_q;
    s2_shift_d  = s2_shift_q;
    s2_sat_d    = s2_sat_q;
    acc_d       = acc_q;
    s3_done_d   = s3_done_q;
    s3_shift_d  = s3_shift_q;
    s3_sat_d    = s3_sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;

    if (accept) begin
      tap_cnt_d = grp_last ? '0 : tap_cnt_q + KW'(1);
      if (grp_first) begin
        k_d     = k_eff;
        shift_d = cfg_shift;
        sat_d   = cfg_sat;
      end
    end

    // Shift/sat ride along with every tap so a new group can start while the
    // previous group's last tap is still in flight.
    if (adv) begin
      s1_valid_d = bus.in_valid;
      s1_first_d = grp_first;
      s1_last_d  = grp_last;
      s1_w_d     = bus.weight;
      s1_f_d     = bus.feature;
      s1_shift_d = grp_shift;
      s1_sat_d   = grp_sat;

      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_prod_d  = PW'(s1_w_q) * PW'(s1_f_q);
      s2_shift_d = s1_shift_q;
      s2_sat_d   = s1_sat_q;

      if (s2_valid_q) begin
        acc_d = s2_first_q ? ACC_W'(s2_prod_q) : acc_q + ACC_W'(s2_prod_q);
      end
      s3_done_d  = s2_valid_q && s2_last_q;
      s3_shift_d = s2_shift_q;
      s3_sat_d   = s2_sat_q;

      out_valid_d = s3_done_q;
      if (s3_done_q) begin
        out_data_d = rs_data;
        out_ovf_d  = rs_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tap_cnt_q   <= '0;
      k_q         <= '0;
      shift_q     <= '0;
      sat_q       <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_w_q      <= '0;
      s1_f_q      <= '0;
      s1_shift_q  <= '0;
      s1_sat_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_prod_q   <= '0;
      s2_shift_q  <= '0;
      s2_sat_q    <= 1'b0;
      acc_q       <= '0;
      s3_done_q   <= 1'b0;
      s3_shift_q  <= '0;
      s3_sat_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      tap_cnt_q   <= tap_cnt_d;
      k_q         <= k_d;
      shift_q     <= shift_d;
      sat_q       <= sat_d;
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_w_q      <= s1_w_d;
      s1_f_q      <= s1_f_d;
      s1_shift_q  <= s1_shift_d;
      s1_sat_q    <= s1_sat_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_prod_q   <= s2_prod_d;
      s2_shift_q  <= s2_shift_d;
      s2_sat_q    <= s2_sat_d;
      acc_q       <= acc_d;
      s3_done_q   <= s3_done_d;
      s3_shift_q  <= s3_shift_d;
      s3_sat_q    <= s3_sat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: doc/mac_acc_pipe.md
# mac_acc_pipe

Pipelined, parametrised signed multiply-accumulate engine for the conv1d datapath. It is the registered successor to the single-cycle combinational MAC. It accepts one weight/feature pair per cycle under valid/ready handshake and accumulates a programmable number of taps (kernel length). It emits one rounded, optionally saturated result per group and stalls the whole pipeline under output backpressure.

## Interface
Parameters:
- DATA_W, `WIDTH_DATA: signed operand width
- K_MAX, 16: maximum taps per group
- ACC_W, 2*DATA_W+$clog2(K_MAX): accumulator width; must be ≥ 2*DATA_W+$clog2(K_MAX), checked at elaboration
- OUT_W, 2*DATA_W: result width

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- cfg_k  in  $clog2(K_MAX+1)  taps per group; sampled on first tap of a group; 0 treated as 1; values > K_MAX clamp to K_MAX
- cfg_shift  in  $clog2(ACC_W)  arithmetic right shift applied to result; sampled with cfg_k
- cfg_sat  in  1  1 = saturate to OUT_W, 0 = truncate; sampled with cfg_k
- in_valid  in  1  weight/feature pair valid
- in_ready  out  1  pipeline accepting
- weight  in  DATA_W  signed weight
- feature  in  DATA_W  signed feature
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepting
- out_data  out  OUT_W  signed result
- out_ovf  out  1  result exceeded OUT_W range; saturation occurred when cfg_sat=1

## Operation
- Global advance `adv = !out_valid || out_ready`; `in_ready = adv`. All stages hold when !adv.
- Stage S1: register weight, feature, valid, first flag (tap_cnt==0), and last flag (tap_cnt==k_lat-1).
- Stage S2: signed product, 2*DATA_W bits, registered with valid/first/last.
- Stage S3: accumulator. first: acc ← sext(prod); else acc ← acc + sext(prod). On a valid last, the round/shift/saturate result is loaded into the output register.
- Tap counter: increments on each accepted input (in_valid && in_ready); wraps to 0 after k_lat-1. k_lat/shift/sat latch when an input is accepted with tap_cnt==0.
- Result: r = (acc + (shift>0 ? 1<<(shift-1) : 0)) >>> shift (round half up). If r lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1]: out_ovf=1 and out_data = clamp (cfg_sat=1) or low OUT_W bits (cfg_sat=0). Otherwise out_ovf=0.
- Config changes mid-group have no effect until the next group start.
- Bubbles (in_valid=0 while in_ready=1) insert invalid slots. The accumulator holds and the group continues.

## Timing
- Reset: in_ready=1 after the reset cycle. out_valid=0, out_data=0, out_ovf=0, tap_cnt=0, acc=0, all stage valids 0.
- Latency: last tap accepted at edge t → out_valid=1 after edge t+3, with no stalls. Each stall cycle adds one.
- Throughput: one tap per cycle. With k_lat=1, one result per cycle back-to-back.
- out_valid && !out_ready: out_data/out_ovf held stable, in_ready=0, no stage advances, no input lost.
- Output accepted and a new result arriving in the same cycle: the new result replaces the old one with no bubble.
- Reset mid-group or mid-stall discards partial sums and any pending output.

## Structure
- The shared header define.v supplies `WIDTH_DATA, the DATA_W default. A shared function for the round/shift/saturate step lives alongside it for reuse by the future requantiser.
- Sub-module mac_round_sat: combinational, params ACC_W/OUT_W; inputs acc, shift, sat; outputs data, ovf.
- Multiplier is behavioural `*` in S2. A Booth/Wallace replacement must keep the one-cycle S2 contract.

## Test plan
- cfg_k=3, shift=0, sat=1; taps (2,3),(-4,5),(7,1) consecutive, out_ready=1 → one result 3 cycles after last tap: out_data=-7, out_ovf=0.
- cfg_k=1, 8 back-to-back pairs (i,i) for i=0..7 → 8 consecutive out_valid cycles with data 0,1,4,…,49.
- DATA_W=8, OUT_W=8, cfg_k=4, sat=1, four taps (127,127) → out_data=127, out_ovf=1. With sat=0 → out_data=low 8 bits of 64516 (=4, i.e. 0x04), out_ovf=1.
- cfg_shift=2, single tap (3,3): 9 → (9+2)>>>2 = 2. Tap (-3,3): -9 → (-9+2)>>>2 = -2.
- cfg_k=4; hold out_ready=0 for 5 cycles while a result is pending, with in_valid=1 throughout → in_ready=0 during the stall, out_data stable, no tap lost, next group result correct.
- Assert rst after 2 of 4 taps, then send a fresh 4-tap group → result equals the fresh group's sum only, with no residue.
